// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle fetch/decode/execute sequencer:
// state encoding, opcode values and field widths.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } seq_state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_JUMP  = 2'b11;

    localparam int JUMP_OFS_W   = 6;
    localparam int RETIRE_CNT_W = 16;

endpackage

// File: rtl/multicycle_sequencer_pc_unit.sv
// Program counter: synchronous reset to 0, +1 after a fetch, and a
// sign-extended relative add for taken jumps. All arithmetic wraps.
module seq_pc_unit
    import multicycle_sequencer_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_en_i,
    input  logic                  jump_en_i,
    input  logic [JUMP_OFS_W-1:0] ofs_i,
    output logic [PC_W-1:0]       pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] ofs_sext;

    assign ofs_sext = {{(PC_W-JUMP_OFS_W){ofs_i[JUMP_OFS_W-1]}}, ofs_i};

    // Next PC: increment and jump are never requested in the same cycle.
    always_comb begin
        pc_d = pc_q;
        if (inc_en_i) begin
            pc_d = pc_q + PC_W'(1);
        end else if (jump_en_i) begin
            pc_d = pc_q + ofs_sext;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 2-bit-opcode CPU.
// Owns PC and IR, handshakes with instruction and data memory, and drives
// datapath strobes as Moore outputs of (state, registered opcode).
// Optional build macro SEQ_RETIRE_CNT_EN adds a saturating retire counter.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               instr_req,
    output logic [PC_W-1:0]    instr_addr,
    input  logic [INSTR_W-1:0] instr_rdata,
    input  logic               instr_ack,
    input  logic               mem_ack,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               alu_sel,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               branch,
    output logic               busy,
`ifdef SEQ_RETIRE_CNT_EN
    output logic [RETIRE_CNT_W-1:0] retired_cnt,
`endif
    output logic [2:0]         state
);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;
    logic [1:0]         op;
    logic               pc_inc;
    logic               pc_jump;
    logic               retire;

    assign op = ir_q[INSTR_W-1 -: 2];

    seq_pc_unit #(
        .PC_W (PC_W)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .inc_en_i  (pc_inc),
        .jump_en_i (pc_jump),
        .ofs_i     (ir_q[JUMP_OFS_W-1:0]),
        .pc_o      (pc)
    );

    // Next-state, IR load, PC control and Moore strobes.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_inc    = 1'b0;
        pc_jump   = 1'b0;
        retire    = 1'b0;
        instr_req = 1'b0;
        alu_sel   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                instr_req = 1'b1;
                if (instr_ack) begin
                    ir_d    = instr_rdata;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op)
                    OP_ADD: begin
                        alu_sel = 1'b1;
                        state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        state_d = ST_MEM;
                    end
                    default: begin
                        branch  = 1'b1;
                        pc_jump = 1'b1;
                        retire  = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                mem_read  = (op == OP_LOAD);
                mem_write = (op == OP_STORE);
                if (mem_ack) begin
                    if (op == OP_LOAD) state_d = ST_WB;
                    else               retire  = 1'b1;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // run is only consulted when an instruction finishes.
        if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    end

    // State and instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic [RETIRE_CNT_W-1:0] retire_cnt_q;

    // Saturating count of retired instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else if (retire && (retire_cnt_q != {RETIRE_CNT_W{1'b1}})) begin
            retire_cnt_q <= retire_cnt_q + RETIRE_CNT_W'(1);
        end
    end

    assign retired_cnt = retire_cnt_q;
`endif

    assign instr_addr = pc;
    assign ir         = ir_q;
    assign busy       = (state_q != ST_IDLE);
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       instr_req;
    logic [7:0] instr_addr;
    logic [7:0] instr_rdata;
    logic       instr_ack;
    logic       mem_ack;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       alu_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       busy;
    logic [2:0] state;
`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retired_cnt;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_rdata (instr_rdata),
        .instr_ack   (instr_ack),
        .mem_ack     (mem_ack),
        .pc          (pc),
        .ir          (ir),
        .alu_sel     (alu_sel),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .busy        (busy),
`ifdef SEQ_RETIRE_CNT_EN
        .retired_cnt (retired_cnt),
`endif
        .state       (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the five datapath strobes at once (alu, rw, rd, wr, br).
    task automatic check_strobes(input string tag, input logic [4:0] exp);
        check({tag, "_alu"}, 32'(alu_sel),   32'(exp[4]));
        check({tag, "_rw"},  32'(reg_write), 32'(exp[3]));
        check({tag, "_rd"},  32'(mem_read),  32'(exp[2]));
        check({tag, "_wr"},  32'(mem_write), 32'(exp[1]));
        check({tag, "_br"},  32'(branch),    32'(exp[0]));
    endtask

    // Entered in FETCH with run=1; zero-wait JUMP, ends in the next FETCH.
    task automatic do_jump(input logic [7:0] instr, input logic [7:0] exp_pc);
        check("jmp_req", 32'(instr_req), 32'd1);
        instr_ack   = 1'b1;
        instr_rdata = instr;
        tick();
        instr_ack = 1'b0;
        check("jmp_decode", 32'(state), 32'd2);
        check_strobes("jmp_dec", 5'b00000);
        tick();
        check("jmp_exec", 32'(state), 32'd3);
        check_strobes("jmp_exe", 5'b00001);
        tick();
        check("jmp_refetch", 32'(state), 32'd1);
        check("jmp_br_off", 32'(branch), 32'd0);
        check("jmp_pc", 32'(pc), 32'(exp_pc));
        check("jmp_addr", 32'(instr_addr), 32'(exp_pc));
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        instr_rdata = 8'h00;
        instr_ack   = 1'b0;
        mem_ack     = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(instr_req), 32'd0);
        check("rst_addr", 32'(instr_addr), 32'd0);
        check_strobes("rst", 5'b00000);
        reset = 1'b0;

        // ADD 8'h00, zero wait
        run = 1'b1;
        tick();
        check("add_fetch", 32'(state), 32'd1);
        check("add_req", 32'(instr_req), 32'd1);
        check("add_busy", 32'(busy), 32'd1);
        instr_ack   = 1'b1;
        instr_rdata = 8'h00;
        tick();
        instr_ack = 1'b0;
        check("add_decode", 32'(state), 32'd2);
        check("add_pc", 32'(pc), 32'd1);
        check("add_req_off", 32'(instr_req), 32'd0);
        check_strobes("add_dec", 5'b00000);
        tick();
        check("add_exec", 32'(state), 32'd3);
        check_strobes("add_exe", 5'b10000);
        tick();
        check("add_wb", 32'(state), 32'd5);
        check_strobes("add_wb", 5'b01000);
        run = 1'b0;
        tick();
        check("add_idle", 32'(state), 32'd0);
        check("add_busy_off", 32'(busy), 32'd0);
        check_strobes("add_done", 5'b00000);

        // LOAD 8'h40, mem_ack after 3 wait cycles; stray acks along the way
        run = 1'b1;
        tick();
        check("ld_fetch", 32'(state), 32'd1);
        instr_ack   = 1'b1;
        mem_ack     = 1'b1;
        instr_rdata = 8'h40;
        tick();
        instr_ack = 1'b0;
        mem_ack   = 1'b0;
        check("ld_decode", 32'(state), 32'd2);
        check("ld_ir", 32'(ir), 32'h40);
        check("ld_pc", 32'(pc), 32'd2);
        tick();
        check("ld_exec", 32'(state), 32'd3);
        check_strobes("ld_exe", 5'b00000);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("ld_mem", 32'(state), 32'd4);
            check_strobes("ld_mem", 5'b00100);
            if (i == 1) begin
                instr_ack   = 1'b1;
                instr_rdata = 8'hAA;
            end else begin
                instr_ack = 1'b0;
            end
            mem_ack = (i == 3);
            tick();
        end
        mem_ack   = 1'b0;
        instr_ack = 1'b0;
        check("ld_wb", 32'(state), 32'd5);
        check_strobes("ld_wb", 5'b01000);
        check("ld_ir_kept", 32'(ir), 32'h40);
        check("ld_pc_kept", 32'(pc), 32'd2);
        run = 1'b0;
        tick();
        check("ld_idle", 32'(state), 32'd0);

        // JUMP chain: 2 -> 0x10 -> 0x0F -> 0xFF -> 0x01 (wrap)
        run = 1'b1;
        tick();
        do_jump(8'hCD, 8'h10);
        do_jump(8'hFE, 8'h0F);
        do_jump(8'hEF, 8'hFF);
        do_jump(8'hC1, 8'h01);

        // STORE 8'h80 with run dropped during the MEM wait
        instr_ack   = 1'b1;
        instr_rdata = 8'h80;
        tick();
        instr_ack = 1'b0;
        check("st_pc", 32'(pc), 32'd2);
        tick();
        check("st_exec", 32'(state), 32'd3);
        check_strobes("st_exe", 5'b00000);
        tick();
        check("st_mem", 32'(state), 32'd4);
        check_strobes("st_mem", 5'b00010);
        run = 1'b0;
        tick();
        check("st_mem_hold", 32'(state), 32'd4);
        check("st_wr_hold", 32'(mem_write), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("st_idle", 32'(state), 32'd0);
        check("st_busy", 32'(busy), 32'd0);
        check_strobes("st_done", 5'b00000);
        tick();
        check("st_no_req", 32'(instr_req), 32'd0);
        check("st_still_idle", 32'(state), 32'd0);

        // Reset in FETCH, then a late instr_ack is ignored
        run = 1'b1;
        tick();
        check("rf_req", 32'(instr_req), 32'd1);
        reset = 1'b1;
        run   = 1'b0;
        tick();
        reset       = 1'b0;
        instr_ack   = 1'b1;
        instr_rdata = 8'h55;
        check("rf_state", 32'(state), 32'd0);
        check("rf_pc", 32'(pc), 32'd0);
        check("rf_ir", 32'(ir), 32'd0);
        check("rf_req_off", 32'(instr_req), 32'd0);
        tick();
        instr_ack = 1'b0;
        check("rf_ack_state", 32'(state), 32'd0);
        check("rf_ack_ir", 32'(ir), 32'd0);
        check("rf_ack_pc", 32'(pc), 32'd0);

`ifdef SEQ_RETIRE_CNT_EN
        // Retire counter: 5 jumps, then saturation from 16'hFFFE
        check("rc_zero", 32'(retired_cnt), 32'd0);
        run = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            do_jump(8'hC0, 8'(i));
        end
        check("rc_five", 32'(retired_cnt), 32'd5);
        dut.retire_cnt_q = 16'hFFFE;
        do_jump(8'hC0, 8'h06);
        check("rc_ffff_1", 32'(retired_cnt), 32'h0000FFFF);
        do_jump(8'hC0, 8'h07);
        do_jump(8'hC0, 8'h08);
        check("rc_sat", 32'(retired_cnt), 32'h0000FFFF);
        run = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 2-bit-opcode microprocessor (ADD=00, LOAD=01, STORE=10, JUMP=11).
- Owns PC and instruction register (IR).
- Handshakes with instruction and data memory.
- Drives datapath controls (alu_sel, reg_write, mem_read, mem_write, branch) one phase at a time; replaces the purely combinational decode path.

Parameters:
PC_W, 8, PC / instruction address width
INSTR_W, 8, instruction width; op = ir[INSTR_W-1:INSTR_W-2], jump offset = ir[5:0]

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
run  input  1  level enable; sampled only in IDLE and at instruction retire
instr_req  output  1  instruction fetch request, held until instr_ack
instr_addr  output  PC_W  fetch address (= pc)
instr_rdata  input  INSTR_W  fetched instruction, valid with instr_ack
instr_ack  input  1  fetch complete
mem_ack  input  1  data memory access complete
pc  output  PC_W  current PC
ir  output  INSTR_W  latched instruction
alu_sel  output  1  ALU add select
reg_write  output  1  register file write strobe
mem_read  output  1  data read request, held until mem_ack
mem_write  output  1  data write request, held until mem_ack
branch  output  1  jump-taken strobe
busy  output  1  high in any state except IDLE
state  output  3  encoded FSM state, for debug

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset:
  - Next edge: state=IDLE, pc=0, ir=0.
  - All outputs 0 except instr_addr=pc=0.
  - Reset mid-access abandons the request; a later ack is ignored.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- Outputs are Moore functions of state and registered op; no combinational path from any input to any output.
- IDLE: run=1 -> FETCH; else stay.
- FETCH:
  - instr_req=1.
  - On instr_ack: ir<=instr_rdata, pc<=pc+1 (mod 2^PC_W), -> DECODE.
  - Without ack: stay, req held, instr_addr stable.
- DECODE: one cycle, no strobes, -> EXEC.
- EXEC:
  - ADD: alu_sel=1, -> WB.
  - LOAD/STORE: -> MEM; alu_sel=0.
  - JUMP: branch=1 for exactly one cycle; pc<=pc+sext(ir[5:0]), computed from the already-incremented pc, wraps mod 2^PC_W. Then retire.
- MEM:
  - LOAD: mem_read=1. STORE: mem_write=1. Held until mem_ack.
  - LOAD+ack -> WB. STORE+ack -> retire.
  - alu_sel=0 throughout.
- WB: reg_write=1 for exactly one cycle (ADD and LOAD), then retire.
- Retire: run=1 -> FETCH; run=0 -> IDLE.
- run=0 mid-instruction never aborts; the instruction completes first.
- Zero-wait latency (ack in the first request cycle):
  - JUMP 3 cycles; ADD 4; STORE 4; LOAD 5.
  - Each wait cycle adds 1.
- Ack handling:
  - An ack in a state that does not request it is ignored.
  - instr_ack and mem_ack together: only the one matching the current state counts.
- Invariant: mem_read and mem_write are never both 1.

Optional Feature:
- Macro SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output retired_cnt [15:0], reset to 0.
  - Increments by 1 on each retire cycle; saturates at 16'hFFFF.
  - Reset clears it.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package:
  - state encoding constants (IDLE..WB)
  - opcode constants OP_ADD/OP_LOAD/OP_STORE/OP_JUMP
  - JUMP_OFS_W=6
  - RETIRE_CNT_W=16
- One sub-module, seq_pc_unit: PC register with reset, +1 increment, signed relative-jump add.

Test Plan:
- Reset, run=1, fetch 8'h00 (ADD), zero-wait acks -> alu_sel in EXEC, reg_write 1 cycle in WB, pc=1, retire at cycle 4.
- LOAD 8'h40, mem_ack delayed 3 cycles -> mem_read held 4 cycles, then reg_write 1 cycle, total 8 cycles; mem_write stays 0.
- pc=8'h10, JUMP 8'hFE (offset -2) -> branch 1 cycle, pc=8'h0F; then pc=8'hFF with JUMP 8'hC1 (offset +1) -> pc wraps to 8'h01.
- Drop run during STORE MEM wait -> STORE completes on mem_ack, FSM enters IDLE, busy=0, no further instr_req.
- Assert reset during FETCH with instr_req=1, then pulse instr_ack -> state IDLE, pc=0, ir=0, ack ignored.
- SEQ_RETIRE_CNT_EN defined: run 5 instructions -> retired_cnt=5; preload 16'hFFFE, retire 3 -> retired_cnt=16'hFFFF.
